// File: rtl/div_seq_param.sv
// div_seq_param: sequential restoring divider (signed/unsigned), quotient on lo, remainder on hi.
// One quotient bit per cycle; a FIX cycle applies result signs.
module div_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, r_q, r_dvs, r_hi, r_lo;
    logic [CW-1:0]    r_cnt;
    logic             r_sd, r_sv, r_done, r_dz;
    logic             w_sd, w_sv, w_zero;
    logic [WIDTH:0]   w_shift, w_trial;

    assign w_sd    = signed_op & dividend[WIDTH-1];
    assign w_sv    = signed_op & divisor[WIDTH-1];
    assign w_zero  = divisor == '0;
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};

    assign busy    = r_state != IDLE;
    assign done    = r_done;
    assign divzero = r_dz;
    assign hi      = r_hi;
    assign lo      = r_lo;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (start && !w_zero) ? RUN : IDLE;
            RUN:     w_state_nxt = (r_cnt == CW'(1)) ? FIX : RUN;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc  <= '0;
            r_q    <= '0;
            r_dvs  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_sd   <= 1'b0;
            r_sv   <= 1'b0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    if (w_zero) begin
                        r_dz   <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_dz  <= 1'b0;
                        r_sd  <= w_sd;
                        r_sv  <= w_sv;
                        r_q   <= w_sd ? -dividend : dividend;
                        r_dvs <= w_sv ? -divisor : divisor;
                        r_acc <= '0;
                        r_cnt <= CW'(WIDTH);
                    end
                end
                // a negative trial means restore: the shifted value already fits in WIDTH bits
                RUN: begin
                    r_acc <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_lo   <= (r_sd ^ r_sv) ? -r_q : r_q;
                    r_hi   <= r_sd ? -r_acc : r_acc;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq_param.sv
// tb_div_seq_param: scoreboard bench for div_seq_param at WIDTH 32 and 8.
module tb_div_seq_param;
    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        int          due;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic        start = 1'b0, signed_op = 1'b0;
    logic [31:0] dividend = '0, divisor = '0;
    logic        busy, done, divzero;
    logic [31:0] hi, lo;
    logic        start8 = 1'b0, sop8 = 1'b0;
    logic [7:0]  dd8 = '0, dv8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;
    int          cyc = 0, n_pass = 0, n_total = 0;
    exp_t        q32[$], q8[$];

    div_seq_param #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .divzero(divzero), .hi(hi), .lo(lo));

    div_seq_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_op(sop8),
        .dividend(dd8), .divisor(dv8), .busy(busy8), .done(done8),
        .divzero(dz8), .hi(hi8), .lo(lo8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic push(input bit w8, input logic [63:0] ehi, input logic [63:0] elo,
                        input logic edz, input int due);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.due = due;
        if (w8) q8.push_back(e);
        else    q32.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q32.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done32 at cycle %0d", cyc);
            end else begin
                e = q32.pop_front();
                chk("lo32", 64'(lo), e.lo);
                chk("hi32", 64'(hi), e.hi);
                chk("divzero32", 64'(divzero), 64'(e.dz));
                chk("latency32", 64'(cyc), 64'(e.due));
                chk("busy_at_done32", 64'(busy), 64'd0);
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done8 at cycle %0d", cyc);
            end else begin
                e = q8.pop_front();
                chk("lo8", 64'(lo8), e.lo);
                chk("hi8", 64'(hi8), e.hi);
                chk("divzero8", 64'(dz8), 64'(e.dz));
                chk("latency8", 64'(cyc), 64'(e.due));
            end
        end
    end

    // drive at a negedge; accepting edge is the next posedge
    task automatic issue(input logic sop, input logic [31:0] dd, input logic [31:0] dv,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        signed_op = sop; dividend = dd; divisor = dv; start = 1'b1;
        push(1'b0, 64'(ehi), 64'(elo), edz, cyc + (edz ? 1 : 34));
        @(negedge clk);
        start = 1'b0;
        if (edz) chk("busy_divzero", 64'(busy), 64'd0);
    endtask

    task automatic issue8(input logic sop, input logic [7:0] dd, input logic [7:0] dv,
                          input logic [7:0] ehi, input logic [7:0] elo);
        sop8 = sop; dd8 = dd; dv8 = dv; start8 = 1'b1;
        push(1'b1, 64'(ehi), 64'(elo), 1'b0, cyc + 10);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_q();
        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        if (q32.size() != 0 || q8.size() != 0) begin
            n_total++;
            $display("FAIL timeout: %0d results outstanding", q32.size() + q8.size());
            q32.delete();
            q8.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divzero", 64'(divzero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b1, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0); wait_q();
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0); wait_q();
        issue(1'b0, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0); wait_q();
        issue(1'b1, 32'hFFFFFFFF, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0); wait_q();
        issue(1'b0, 32'd23, 32'd6, 32'h5, 32'h3, 1'b0); wait_q();
        issue(1'b0, 32'd100, 32'd0, 32'h5, 32'h3, 1'b1); wait_q();
        chk("divzero_held", 64'(divzero), 64'd1);
        issue(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0); wait_q();
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0); wait_q();
        // start mid-run must be ignored
        issue(1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0);
        repeat (4) @(negedge clk);
        signed_op = 1'b1; dividend = 32'd50; divisor = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_q();
        // start held through done: second op accepted with no idle cycle
        c = cyc;
        signed_op = 1'b0; dividend = 32'h12345678; divisor = 32'h100; start = 1'b1;
        push(1'b0, 64'h78, 64'h123456, 1'b0, c + 34);
        push(1'b0, 64'hFFFFFFFE, 64'hFFFFFFF2, 1'b0, c + 68);
        @(negedge clk);
        signed_op = 1'b1; dividend = 32'hFFFFFF9C; divisor = 32'd7;
        repeat (34) @(negedge clk);
        start = 1'b0;
        wait_q();
        // reset mid-operation
        issue(1'b0, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        q32.delete();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0); wait_q();
        issue8(1'b1, 8'h80, 8'hFF, 8'h00, 8'h80); wait_q();
        issue8(1'b1, 8'h07, 8'hFE, 8'h01, 8'hFD); wait_q();
        issue8(1'b0, 8'hFF, 8'h10, 8'h0F, 8'h0F); wait_q();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/div_seq_param.md
# div_seq_param

Parametrised sequential restoring divider for the CPU's multi-cycle datapath. It serves both DIV (signed) and DIVU (unsigned) from a single instance. It produces quotient on `lo` and remainder on `hi`, and flags divide-by-zero. A start/busy/done handshake lets the control unit stall until the result is valid.

## Interface
- `WIDTH`, 32, operand and result width in bits; legal range 4..64.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; low forces every register to its reset value immediately.
- `start`  in  1  operation request; sampled only in IDLE.
- `signed_op`  in  1  1 = two's-complement division, 0 = unsigned; sampled with `start`.
- `dividend`  in  WIDTH  numerator; sampled with `start`.
- `divisor`  in  WIDTH  denominator; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse when `hi`/`lo`/`divzero` are updated.
- `divzero`  out  1  last operation had divisor == 0; held until the next accepted `start`.
- `hi`  out  WIDTH  remainder of last completed operation.
- `lo`  out  WIDTH  quotient of last completed operation.

## Operation
- States: IDLE, RUN, FIX.
- Reset values: state = IDLE; `busy`, `done` and `divzero` = 0; `hi` and `lo` = 0; internal accumulator, shift register and counter = 0.
- IDLE, `start` = 1, divisor != 0:
  - Latch the sign flags: `sd = signed_op & dividend[WIDTH-1]` and `sv = signed_op & divisor[WIDTH-1]`.
  - Latch the magnitudes: `|dividend|` if `sd`, else raw; `|divisor|` if `sv`, else raw.
  - Clear the accumulator (WIDTH+1 bits) and `divzero`.
  - Set counter = WIDTH; go to RUN.
- IDLE, `start` = 1, divisor == 0:
  - Set `divzero` = 1 and pulse `done`.
  - `hi` and `lo` keep their previous values.
  - Stay in IDLE; no RUN cycles.
- RUN, one restoring step per cycle:
  - Shift {acc, q} left 1.
  - trial = acc − divisor_mag.
  - If trial is non-negative: acc = trial and q[0] = 1. Otherwise acc is restored and q[0] = 0.
  - Decrement the counter. When the counter reaches 0 after the step, go to FIX.
- FIX:
  - `lo` = −q if `sd` XOR `sv`, else q.
  - `hi` = −acc[WIDTH-1:0] if `sd`, else acc. The remainder takes the sign of the dividend.
  - Pulse `done`; go to IDLE.
- Arithmetic rules:
  - Negation is two's complement, truncated to WIDTH bits.
  - Signed most-negative / −1: quotient wraps to the most-negative value, remainder 0, `divzero` = 0.
  - Most-negative / 1 gives the most-negative value.
- `start` while `busy`: ignored. Operands and mode are not re-sampled and no extra `done` is produced.
- Operand inputs may change freely after the accepting edge.

## Timing
- Accepting edge = E0. RUN occupies edges E1..EWIDTH. FIX executes at edge EWIDTH+1.
- `hi`, `lo` and `done` are valid after EWIDTH+1, so latency is WIDTH+1 cycles (33 for WIDTH = 32).
- `busy` rises after E0 and falls after EWIDTH+1, coincident with `done` rising.
- Divide-by-zero: `done` and `divzero` are high after E0 itself; `busy` never rises.
- `done` is high for exactly one cycle.
- Back-to-back operation: `start` high in the `done` cycle is accepted at the next edge, giving no dead cycle between operations.
- `reset` low mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - No `done` pulse.
  - The first `start` after `reset` rises is handled normally.

## Test plan
- Signed, WIDTH = 32, 7 / −2 → `lo` = 0xFFFFFFFD, `hi` = 0x00000001, `done` exactly 33 cycles after `start`. Then −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
- Unsigned, 0xFFFFFFFF / 0x10 → `lo` = 0x0FFFFFFF, `hi` = 0xF. Same operands with `signed_op` = 1 → `lo` = 0, `hi` = 0xFFFFFFFF.
- Divide by zero: previous `hi`/`lo` = 0x5/0x3, then 100 / 0 → `divzero` = 1 and `done` on the next cycle, `busy` stays 0, `hi`/`lo` unchanged. The next valid divide clears `divzero`.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0, `divzero` = 0.
- Handshake:
  - Pulse `start` with new operands at cycle 5 of a running divide → ignored; the result matches the first operands and there is a single `done`.
  - Hold `start` high through `done` → second operation accepted with no idle cycle.
- Reset and width:
  - Assert `reset` low at cycle 10 of a divide → `busy` = 0, `hi` = `lo` = 0 immediately, no `done`.
  - Repeat the suite at WIDTH = 8: 0x80 / 0xFF signed → `lo` = 0x80, latency 9 cycles.
